// File: rtl/bitwise_logic_pipe.sv
// Pipelined per-bit logic unit: one of eight bitwise ops, STAGES register stages, valid/ready with whole-pipe stall.
// Optional build macro POPCOUNT_EN adds a registered out_pop (number of 1 bits in out_data) aligned with out_valid.
module bitwise_logic_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count
`ifdef POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_pop
`endif
);

  logic [WIDTH-1:0]  op_result;
  logic              stall;
  logic              out_fire;

  logic [STAGES-1:0] valid_d, valid_q;
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [CNT_W-1:0]  count_d, count_q;

  // The op is resolved here, so only stage 1 sees in_op; later stages just shift.
  always_comb begin
    op_result = '0;
    case (in_op)
      3'b000:  op_result = in_a & in_b;
      3'b001:  op_result = in_a | in_b;
      3'b010:  op_result = in_a ^ in_b;
      3'b011:  op_result = ~(in_a ^ in_b);
      3'b100:  op_result = ~(in_a & in_b);
      3'b101:  op_result = ~(in_a | in_b);
      3'b110:  op_result = in_a;
      3'b111:  op_result = ~in_a;
      default: op_result = '0;
    endcase
  end

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
    end
    if (!stall) begin
      valid_d[0] = in_valid;
      data_d[0]  = op_result;
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (out_fire) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Data is cleared on reset too, so bubbles never carry X downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_count = count_q;

`ifdef POPCOUNT_EN
  localparam int POP_W = $clog2(WIDTH+1);

  logic [WIDTH-1:0] pop_src;
  logic [POP_W-1:0] pop_d, pop_q;

  function automatic logic [POP_W-1:0] count_ones(input logic [WIDTH-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + POP_W'(v[i]);
    end
    return cnt;
  endfunction

  // Count whatever is about to enter the last stage so the count lands with its data.
  if (STAGES == 1) begin : g_pop_src_in
    assign pop_src = op_result;
  end else begin : g_pop_src_stage
    assign pop_src = data_q[STAGES-2];
  end

  always_comb begin
    pop_d = pop_q;
    if (!stall) begin
      pop_d = count_ones(pop_src);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_q <= '0;
    end else begin
      pop_q <= pop_d;
    end
  end

  assign out_pop = pop_q;
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe (WIDTH=8, STAGES=2, CNT_W=8) with a queue scoreboard.
// Build with POPCOUNT_EN defined to also check out_pop.
module tb_bitwise_logic_pipe;

   localparam int WIDTH  = 8;
   localparam int STAGES = 2;
   localparam int CNT_W  = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             inValid;
   logic             inReady;
   logic [WIDTH-1:0] inA;
   logic [WIDTH-1:0] inB;
   logic [2:0]       inOp;
   logic             outValid;
   logic             outReady;
   logic [WIDTH-1:0] outData;
   logic [CNT_W-1:0] outCount;
`ifdef POPCOUNT_EN
   logic [3:0]       outPop;
`endif

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] expQ [$];

   bitwise_logic_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_a      (inA),
      .in_b      (inB),
      .in_op     (inOp),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_data  (outData),
      .out_count (outCount)
`ifdef POPCOUNT_EN
      ,
      .out_pop   (outPop)
`endif
   );

   always #5 clk = ~clk;

   // Reference behaviour of each op, written straight from the op table
   function automatic logic [WIDTH-1:0] modelOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ~(a ^ b);
         3'd4: return ~(a & b);
         3'd5: return ~(a | b);
         3'd6: return a;
         default: return ~a;
      endcase
   endfunction

   // Single comparison point: every check in the bench funnels through here
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one transaction and hold it until accepted; the expected result is queued at acceptance
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op, input logic [WIDTH-1:0] expected);
      inA = a;
      inB = b;
      inOp = op;
      inValid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (inReady) begin
            expQ.push_back(expected);
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
      checkOutput("accept_timeout", 32'(inReady), 32'd1);
   endtask

   // Wait (bounded) until every queued result has left, plus one edge so the counter has settled
   task automatic drainQueue();
      inValid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (expQ.size() == 0) break;
         @(posedge clk);
         #1;
      end
      checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Reset with checks of the cleared outputs while reset is held
   task automatic doReset();
      inValid = 1'b0;
      reset = 1'b1;
      expQ.delete();
      @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("rst_out_data", 32'(outData), 32'd0);
      checkOutput("rst_out_count", 32'(outCount), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("rst_in_ready", 32'(inReady), 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: pop and compare on every output transfer
   always @(negedge clk) begin
      if (!reset && outValid && outReady) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_result", 32'(outData), 32'hFFFF_FFFF);
         end else begin
            logic [WIDTH-1:0] exp;
            exp = expQ.pop_front();
            checkOutput("out_data", 32'(outData), 32'(exp));
`ifdef POPCOUNT_EN
            checkOutput("out_pop", 32'(outPop), 32'($countones(exp)));
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [WIDTH-1:0] sweepExp [8];
      logic [WIDTH-1:0] ra, rb;
      logic [2:0]       rop;
      sweepExp = '{8'h88, 8'hEE, 8'h66, 8'h99, 8'h77, 8'h11, 8'hCC, 8'h33};
      reset = 1'b0;
      inValid = 1'b0;
      inA = '0;
      inB = '0;
      inOp = '0;
      outReady = 1'b1;
      #2;

      // Single XNOR and its two-cycle latency
      doReset();
      applyStimulus(8'hA5, 8'h0F, 3'b011, 8'h55);
      inValid = 1'b0;
      checkOutput("lat_not_early", 32'(outValid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("lat_valid", 32'(outValid), 32'd1);
      checkOutput("xnor_data", 32'(outData), 32'h55);
`ifdef POPCOUNT_EN
      checkOutput("xnor_pop", 32'(outPop), 32'd4);
`endif
      @(posedge clk);
      #1;
      checkOutput("xnor_count", 32'(outCount), 32'd1);
      checkOutput("xnor_done", 32'(outValid), 32'd0);

      // Op sweep back-to-back; full rate means all 8 have left three edges after the last accept
      doReset();
      for (int op = 0; op < 8; op++) begin
         applyStimulus(8'hCC, 8'hAA, 3'(op), sweepExp[op]);
      end
      inValid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("sweep_rate_count", 32'(outCount), 32'd8);
      checkOutput("sweep_queue", 32'(expQ.size()), 32'd0);

      // Backpressure: first result leaves, then the consumer stalls for three cycles
      doReset();
      applyStimulus(8'h3C, 8'h0F, 3'b000, modelOp(8'h3C, 8'h0F, 3'b000));
      applyStimulus(8'h3C, 8'h0F, 3'b010, modelOp(8'h3C, 8'h0F, 3'b010));
      applyStimulus(8'h3C, 8'h0F, 3'b101, modelOp(8'h3C, 8'h0F, 3'b101));
      outReady = 1'b0;
      inA = 8'h5A;
      inB = 8'hFF;
      inOp = 3'b100;
      inValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("stall_in_ready", 32'(inReady), 32'd0);
         checkOutput("stall_valid", 32'(outValid), 32'd1);
         checkOutput("stall_data", 32'(outData), 32'h33);
         @(posedge clk);
         #1;
      end
      outReady = 1'b1;
      applyStimulus(8'h5A, 8'hFF, 3'b100, modelOp(8'h5A, 8'hFF, 3'b100));
      drainQueue();
      checkOutput("bp_count", 32'(outCount), 32'd4);

      // Bubble pattern 1,0,1 appears two cycles later
      doReset();
      inA = 8'hF0; inB = 8'h0F; inOp = 3'b001; inValid = 1'b1;
      expQ.push_back(8'hFF);
      @(posedge clk); #1;
      inValid = 1'b0;
      @(posedge clk); #1;
      inA = 8'h81; inB = 8'h00; inOp = 3'b111; inValid = 1'b1;
      expQ.push_back(8'h7E);
      checkOutput("bubble_v0", 32'(outValid), 32'd1);
      @(posedge clk); #1;
      inValid = 1'b0;
      checkOutput("bubble_v1", 32'(outValid), 32'd0);
      @(posedge clk); #1;
      checkOutput("bubble_v2", 32'(outValid), 32'd1);
      drainQueue();
      checkOutput("bubble_count", 32'(outCount), 32'd2);

      // Counter wrap after 256 results, random operands checked against the model
      doReset();
      for (int i = 0; i < 256; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rop = 3'($urandom_range(0, 7));
         applyStimulus(ra, rb, rop, modelOp(ra, rb, rop));
      end
      drainQueue();
      checkOutput("wrap_count0", 32'(outCount), 32'd0);
      applyStimulus(8'h12, 8'h34, 3'b110, 8'h12);
      drainQueue();
      checkOutput("wrap_count1", 32'(outCount), 32'd1);

      // Mid-stream reset with two results in flight
      applyStimulus(8'hAA, 8'h55, 3'b001, 8'hFF);
      applyStimulus(8'hAA, 8'h55, 3'b000, 8'h00);
      inValid = 1'b0;
      checkOutput("mid_pre_valid", 32'(outValid), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("mid_async_valid", 32'(outValid), 32'd0);
      checkOutput("mid_async_data", 32'(outData), 32'd0);
      checkOutput("mid_async_count", 32'(outCount), 32'd0);
      expQ.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checkOutput("mid_no_ghost", 32'(outValid), 32'd0);
      end
      checkOutput("mid_count_after", 32'(outCount), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
